// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer: entry layout, depth, widths.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 32;
  localparam int IDX_W     = $clog2(ROB_DEPTH);
  localparam int DATA_W    = 32;
  localparam int REG_W     = 6;
  localparam int NUM_REGS  = 1 << REG_W;
  localparam int NUM_FU    = 3;

  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              store;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] value;
  } rob_entry;

  function automatic logic is_store_op(input logic [6:0] opcode);
    return opcode == OP_STORE;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: dual dispatch, three FU completion ports,
// up to two retires per cycle with a registered commit interface.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_valid_1,
  input  logic [REG_W-1:0]  disp_rd_1,
  input  logic              disp_store_1,
  input  logic              disp_valid_2,
  input  logic [REG_W-1:0]  disp_rd_2,
  input  logic              disp_store_2,
  output logic              disp_ready,
  output logic [IDX_W-1:0]  alloc_idx_1,
  output logic [IDX_W-1:0]  alloc_idx_2,
  input  logic [2:0]        cmpl_valid,
  input  logic [IDX_W-1:0]  cmpl_idx_0,
  input  logic [IDX_W-1:0]  cmpl_idx_1,
  input  logic [IDX_W-1:0]  cmpl_idx_2,
  input  logic [DATA_W-1:0] cmpl_val_0,
  input  logic [DATA_W-1:0] cmpl_val_1,
  input  logic [DATA_W-1:0] cmpl_val_2,
  output logic              commit_valid_1,
  output logic              commit_we_1,
  output logic [REG_W-1:0]  commit_rd_1,
  output logic [DATA_W-1:0] commit_val_1,
  output logic              commit_valid_2,
  output logic              commit_we_2,
  output logic [REG_W-1:0]  commit_rd_2,
  output logic [DATA_W-1:0] commit_val_2,
  output logic [63:0]       reg_ready_mask,
  output logic [IDX_W:0]    count,
  output logic              err_sticky
);

  localparam logic [IDX_W:0] READY_MAX = (IDX_W+1)'(ROB_DEPTH - 2);

  rob_entry rob [0:ROB_DEPTH-1];

  logic [IDX_W-1:0]  head, tail, head_p1;
  logic [IDX_W-1:0]  cidx [NUM_FU];
  logic [DATA_W-1:0] cval [NUM_FU];
  logic [NUM_FU-1:0] cmpl_ok;
  logic              cmpl_err;
  logic              fire_1, fire_2, disp_err;
  logic              ret_1, ret_2;
  logic [1:0]        n_disp, n_ret;
  logic [63:0]       mask_next;

  assign cidx[0] = cmpl_idx_0;
  assign cidx[1] = cmpl_idx_1;
  assign cidx[2] = cmpl_idx_2;
  assign cval[0] = cmpl_val_0;
  assign cval[1] = cmpl_val_1;
  assign cval[2] = cmpl_val_2;

  // Space check uses the pre-edge count only; retiring entries do not free room this cycle.
  assign disp_ready  = count <= READY_MAX;
  assign alloc_idx_1 = tail;
  assign alloc_idx_2 = tail + IDX_W'(disp_valid_1);
  assign fire_1      = disp_ready & disp_valid_1;
  assign fire_2      = disp_ready & disp_valid_2;
  assign disp_err    = ~disp_ready & (disp_valid_1 | disp_valid_2);
  assign n_disp      = {1'b0, fire_1} + {1'b0, fire_2};

  assign head_p1 = head + IDX_W'(1);
  assign ret_1   = rob[head].valid & rob[head].done;
  assign ret_2   = ret_1 & rob[head_p1].valid & rob[head_p1].done;
  assign n_ret   = {1'b0, ret_1} + {1'b0, ret_2};

  // Entries allocated this cycle are still invalid pre-edge, so completions to them are rejected here too.
  always_comb begin
    logic dup;
    cmpl_ok  = '0;
    cmpl_err = 1'b0;
    dup      = 1'b0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (cmpl_valid[k]) begin
        dup = 1'b0;
        for (int j = 0; j < k; j++) begin
          if (cmpl_valid[j] && (cidx[j] == cidx[k])) dup = 1'b1;
        end
        if (dup || !rob[cidx[k]].valid || rob[cidx[k]].done) cmpl_err = 1'b1;
        else cmpl_ok[k] = 1'b1;
      end
    end
  end

  always_comb begin
    mask_next = '0;
    if (ret_1 && !rob[head].store)    mask_next[rob[head].rd]    = 1'b1;
    if (ret_2 && !rob[head_p1].store) mask_next[rob[head_p1].rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROB_DEPTH; i++) rob[i] <= '0;
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      commit_valid_1 <= 1'b0;
      commit_we_1    <= 1'b0;
      commit_rd_1    <= '0;
      commit_val_1   <= '0;
      commit_valid_2 <= 1'b0;
      commit_we_2    <= 1'b0;
      commit_rd_2    <= '0;
      commit_val_2   <= '0;
      reg_ready_mask <= '0;
      err_sticky     <= 1'b0;
    end else begin
      if (ret_1) begin
        rob[head].valid <= 1'b0;
        rob[head].done  <= 1'b0;
      end
      if (ret_2) begin
        rob[head_p1].valid <= 1'b0;
        rob[head_p1].done  <= 1'b0;
      end
      if (fire_1)
        rob[alloc_idx_1] <= '{valid: 1'b1, done: 1'b0, store: disp_store_1, rd: disp_rd_1, value: '0};
      if (fire_2)
        rob[alloc_idx_2] <= '{valid: 1'b1, done: 1'b0, store: disp_store_2, rd: disp_rd_2, value: '0};
      for (int k = 0; k < NUM_FU; k++) begin
        if (cmpl_ok[k]) begin
          rob[cidx[k]].done  <= 1'b1;
          rob[cidx[k]].value <= cval[k];
        end
      end
      head  <= head + IDX_W'(n_ret);
      tail  <= tail + IDX_W'(n_disp);
      count <= count + (IDX_W+1)'(n_disp) - (IDX_W+1)'(n_ret);

      commit_valid_1 <= ret_1;
      commit_we_1    <= ret_1 & ~rob[head].store;
      commit_rd_1    <= ret_1 ? rob[head].rd : '0;
      commit_val_1   <= ret_1 ? rob[head].value : '0;
      commit_valid_2 <= ret_2;
      commit_we_2    <= ret_2 & ~rob[head_p1].store;
      commit_rd_2    <= ret_2 ? rob[head_p1].rd : '0;
      commit_val_2   <= ret_2 ? rob[head_p1].value : '0;
      reg_ready_mask <= mask_next;
      err_sticky     <= err_sticky | disp_err | cmpl_err;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus random traffic,
// compared each cycle against a program-order queue model.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              disp_valid_1, disp_store_1, disp_valid_2, disp_store_2;
  logic [5:0]        disp_rd_1, disp_rd_2;
  logic              disp_ready;
  logic [4:0]        alloc_idx_1, alloc_idx_2;
  logic [2:0]        cmpl_valid;
  logic [4:0]        cmpl_idx_0, cmpl_idx_1, cmpl_idx_2;
  logic [31:0]       cmpl_val_0, cmpl_val_1, cmpl_val_2;
  logic              commit_valid_1, commit_we_1, commit_valid_2, commit_we_2;
  logic [5:0]        commit_rd_1, commit_rd_2;
  logic [31:0]       commit_val_1, commit_val_2;
  logic [63:0]       reg_ready_mask;
  logic [5:0]        count;
  logic              err_sticky;

  always #5 clk = ~clk;

  reorder_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid_1(disp_valid_1), .disp_rd_1(disp_rd_1), .disp_store_1(disp_store_1),
    .disp_valid_2(disp_valid_2), .disp_rd_2(disp_rd_2), .disp_store_2(disp_store_2),
    .disp_ready(disp_ready), .alloc_idx_1(alloc_idx_1), .alloc_idx_2(alloc_idx_2),
    .cmpl_valid(cmpl_valid),
    .cmpl_idx_0(cmpl_idx_0), .cmpl_idx_1(cmpl_idx_1), .cmpl_idx_2(cmpl_idx_2),
    .cmpl_val_0(cmpl_val_0), .cmpl_val_1(cmpl_val_1), .cmpl_val_2(cmpl_val_2),
    .commit_valid_1(commit_valid_1), .commit_we_1(commit_we_1),
    .commit_rd_1(commit_rd_1), .commit_val_1(commit_val_1),
    .commit_valid_2(commit_valid_2), .commit_we_2(commit_we_2),
    .commit_rd_2(commit_rd_2), .commit_val_2(commit_val_2),
    .reg_ready_mask(reg_ready_mask), .count(count), .err_sticky(err_sticky)
  );

  // Model: in-flight instructions in program order, oldest at the front.
  typedef struct {
    int          idx;
    logic [5:0]  rd;
    logic        st;
    logic        dn;
    logic [31:0] val;
  } ment_t;

  ment_t q[$];
  int    next_idx = 0;
  logic  m_err = 1'b0;
  int    tests = 0;
  int    failed = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    disp_valid_1 = 1'b0; disp_rd_1 = '0; disp_store_1 = 1'b0;
    disp_valid_2 = 1'b0; disp_rd_2 = '0; disp_store_2 = 1'b0;
    cmpl_valid = '0;
    cmpl_idx_0 = '0; cmpl_idx_1 = '0; cmpl_idx_2 = '0;
    cmpl_val_0 = '0; cmpl_val_1 = '0; cmpl_val_2 = '0;
  endtask

  // One clock: drive inputs, check combinational outputs, predict, clock, check registered outputs.
  task automatic step(input logic dv1, input logic [5:0] rd1, input logic s1,
                      input logic dv2, input logic [5:0] rd2, input logic s2,
                      input logic [2:0] cv, input int i0, input int i1, input int i2,
                      input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
    int          ci[3];
    logic [31:0] cvl[3];
    logic        ready, r1, r2, we1, we2, found, ok;
    logic [5:0]  erd1, erd2;
    logic [31:0] ev1, ev2;
    logic [63:0] emask;
    int          a1, a2;
    ment_t       e;
    disp_valid_1 = dv1; disp_rd_1 = rd1; disp_store_1 = s1;
    disp_valid_2 = dv2; disp_rd_2 = rd2; disp_store_2 = s2;
    cmpl_valid = cv;
    cmpl_idx_0 = 5'(i0); cmpl_idx_1 = 5'(i1); cmpl_idx_2 = 5'(i2);
    cmpl_val_0 = v0; cmpl_val_1 = v1; cmpl_val_2 = v2;
    ci = '{i0, i1, i2};
    cvl = '{v0, v1, v2};
    #1;
    ready = (q.size() <= ROB_DEPTH - 2);
    a1 = next_idx;
    a2 = (next_idx + (dv1 ? 1 : 0)) % ROB_DEPTH;
    check("disp_ready", 64'(disp_ready), 64'(ready));
    check("alloc_idx_1", 64'(alloc_idx_1), 64'(a1));
    check("alloc_idx_2", 64'(alloc_idx_2), 64'(a2));

    r1 = 1'b0; r2 = 1'b0; we1 = 1'b0; we2 = 1'b0;
    erd1 = '0; erd2 = '0; ev1 = '0; ev2 = '0;
    if (q.size() > 0) begin
      r1 = q[0].dn; we1 = q[0].dn && !q[0].st; erd1 = q[0].rd; ev1 = q[0].val;
    end
    if (r1 && q.size() > 1) begin
      r2 = q[1].dn; we2 = q[1].dn && !q[1].st; erd2 = q[1].rd; ev2 = q[1].val;
    end
    emask = '0;
    if (we1) emask[erd1] = 1'b1;
    if (we2) emask[erd2] = 1'b1;

    for (int k = 0; k < 3; k++) begin
      if (cv[k]) begin
        found = 1'b0; ok = 1'b0;
        foreach (q[p]) begin
          if (!found && q[p].idx == ci[k]) begin
            found = 1'b1;
            if (!q[p].dn) begin
              q[p].dn = 1'b1; q[p].val = cvl[k]; ok = 1'b1;
            end
          end
        end
        if (!ok) m_err = 1'b1;
      end
    end
    if (r1) void'(q.pop_front());
    if (r2) void'(q.pop_front());
    if (dv1 || dv2) begin
      if (ready) begin
        if (dv1) begin
          e = '{next_idx, rd1, s1, 1'b0, 32'h0};
          q.push_back(e);
          next_idx = (next_idx + 1) % ROB_DEPTH;
        end
        if (dv2) begin
          e = '{next_idx, rd2, s2, 1'b0, 32'h0};
          q.push_back(e);
          next_idx = (next_idx + 1) % ROB_DEPTH;
        end
      end else begin
        m_err = 1'b1;
      end
    end

    @(posedge clk);
    #1;
    set_idle();
    check("commit_valid_1", 64'(commit_valid_1), 64'(r1));
    check("commit_valid_2", 64'(commit_valid_2), 64'(r2));
    check("commit_we_1", 64'(commit_we_1), 64'(we1));
    check("commit_we_2", 64'(commit_we_2), 64'(we2));
    if (r1) begin
      check("commit_rd_1", 64'(commit_rd_1), 64'(erd1));
      check("commit_val_1", 64'(commit_val_1), 64'(ev1));
    end
    if (r2) begin
      check("commit_rd_2", 64'(commit_rd_2), 64'(erd2));
      check("commit_val_2", 64'(commit_val_2), 64'(ev2));
    end
    check("reg_ready_mask", reg_ready_mask, emask);
    check("count", 64'(count), 64'(q.size()));
    check("err_sticky", 64'(err_sticky), 64'(m_err));
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    q.delete();
    next_idx = 0;
    m_err = 1'b0;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_commit_valid_1", 64'(commit_valid_1), 64'd0);
    check("rst_commit_valid_2", 64'(commit_valid_2), 64'd0);
    check("rst_mask", reg_ready_mask, 64'd0);
    check("rst_err", 64'(err_sticky), 64'd0);
    check("rst_ready", 64'(disp_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Completes up to three pending entries per cycle until the model is empty.
  task automatic drain();
    for (int n = 0; n < 60 && q.size() > 0; n++) begin
      int ids[3];
      logic [2:0] cv;
      int c;
      ids = '{0, 0, 0};
      cv = '0;
      c = 0;
      foreach (q[p]) begin
        if (!q[p].dn && c < 3) begin
          ids[c] = q[p].idx; cv[c] = 1'b1; c++;
        end
      end
      step(0, 0, 0, 0, 0, 0, cv, ids[0], ids[1], ids[2], $urandom, $urandom, $urandom);
    end
    check("drain_count", 64'(count), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, failed);
    $fatal(1, "watchdog");
  end

  initial begin
    int pa, pb, ia, ib;
    logic prev;
    set_idle();
    @(negedge clk);
    do_reset();

    // Scenario 1: out-of-order completion, paired retire
    step(1, 6'd5, 0, 1, 6'd6, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    check("t1_count", 64'(count), 64'd2);
    step(0, 0, 0, 0, 0, 0, 3'b001, 1, 0, 0, 32'hAA, 0, 0);
    check("t1_no_commit", 64'(commit_valid_1), 64'd0);
    step(0, 0, 0, 0, 0, 0, 3'b010, 0, 0, 0, 0, 32'h55, 0);
    check("t1_no_commit_same_edge", 64'(commit_valid_1), 64'd0);
    idle();
    check("t1_mask", reg_ready_mask, 64'h60);
    check("t1_val_1", 64'(commit_val_1), 64'h55);
    check("t1_val_2", 64'(commit_val_2), 64'hAA);

    // Scenario 2: fill, overflow, retire while full
    for (int i = 0; i < 16; i++) step(1, 6'($urandom), 0, 1, 6'($urandom), 0, 3'b000, 0, 0, 0, 0, 0, 0);
    check("t2_full_ready", 64'(disp_ready), 64'd0);
    step(1, 6'd1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    check("t2_full_count", 64'(count), 64'd32);
    check("t2_err", 64'(err_sticky), 64'd1);
    step(0, 0, 0, 0, 0, 0, 3'b011, q[0].idx, q[1].idx, 0, 32'h11, 32'h22, 0);
    step(1, 6'd2, 0, 1, 6'd3, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    check("t2_count_30", 64'(count), 64'd30);
    check("t2_ready_again", 64'(disp_ready), 64'd1);
    drain();

    // Scenario 3: paired dispatch with completion one cycle later, pointers wrap
    prev = 1'b0; pa = 0; pb = 0;
    for (int t = 0; t < 40; t++) begin
      ia = next_idx;
      ib = (next_idx + 1) % ROB_DEPTH;
      step(1, 6'($urandom), 1'($urandom), 1, 6'($urandom), 1'($urandom),
           prev ? 3'b011 : 3'b000, pa, pb, 0, $urandom, $urandom, 0);
      pa = ia; pb = ib; prev = 1'b1;
    end
    drain();

    // Scenario 4: store then ALU retire together
    do_reset();
    step(1, 6'd9, 1, 1, 6'd3, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 3'b011, 0, 1, 0, 32'h1234, 32'h5678, 0);
    idle();
    check("t4_we_1", 64'(commit_we_1), 64'd0);
    check("t4_we_2", 64'(commit_we_2), 64'd1);
    check("t4_mask", reg_ready_mask, 64'h8);

    // Scenario 5: three completions at once with head = 2
    step(1, 6'd10, 0, 1, 6'd11, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    step(1, 6'd12, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 3'b111, 2, 3, 4, 32'hA2, 32'hA3, 32'hA4);
    idle();
    check("t5_two_retire", 64'(commit_valid_2), 64'd1);
    check("t5_rd_2", 64'(commit_rd_2), 64'd11);
    check("t5_count", 64'(count), 64'd1);
    idle();
    check("t5_third_val", 64'(commit_val_1), 64'hA4);
    check("t5_single", 64'(commit_valid_2), 64'd0);

    // Random traffic, including protocol errors
    for (int t = 0; t < 300; t++) begin
      int ids[3];
      logic [2:0] cv;
      for (int k = 0; k < 3; k++) begin
        cv[k] = ($urandom_range(0, 99) < 50);
        if (q.size() > 0 && $urandom_range(0, 9) != 0)
          ids[k] = q[$urandom_range(0, q.size() - 1)].idx;
        else
          ids[k] = int'($urandom_range(0, 31));
      end
      step($urandom_range(0, 99) < 60, 6'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 99) < 60, 6'($urandom), $urandom_range(0, 3) == 0,
           cv, ids[0], ids[1], ids[2], $urandom, $urandom, $urandom);
    end
    drain();

    // Scenario 6: reset with ten entries pending
    for (int i = 0; i < 5; i++) step(1, 6'($urandom), 0, 1, 6'($urandom), 0, 3'b000, 0, 0, 0, 0, 0, 0);
    check("t6_pending", 64'(count), 64'd10);
    step(0, 0, 0, 0, 0, 0, 3'b011, q[0].idx, q[1].idx, 0, 32'h77, 32'h88, 0);
    #2;
    do_reset();
    repeat (4) idle();
    check("t6_no_commit", 64'(commit_valid_1), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
